vec_alu_engine: RTL and testbench
=================================

VEC_ALU_ENGINE -- requirements
Module: vec_alu_engine

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 13, BRAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, element width in bits.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, BRAM read latency in cycles (legal range 1-4).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk  in  1  clock, all logic on rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 abort  in  1  cancels the running operation.
REQ-008 op  in  2  operation: 0 add, 1 sub (a-b), 2 mul (low DATA_WIDTH bits of product), 3 signed max.
REQ-009 addr_a, addr_b, addr_out  in  ADDR_WIDTH each  base addresses of A, B, C.
REQ-010 len  in  32  element count.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse on normal completion.
REQ-013 bram_addr_b  out  ADDR_WIDTH; bram_din_b  out  DATA_WIDTH; bram_dout_b  in  DATA_WIDTH; bram_en_b  out  1; bram_we_b  out  1.

Function
REQ-014 op, addr_a, addr_b, addr_out and len SHALL be latched when start is accepted; later input changes SHALL NOT affect the operation in progress.
REQ-015 The FSM SHALL have states IDLE, RD_A, WAIT_A, RD_B, WAIT_B, WR, DONE.
REQ-016 IDLE: start=1 with len!=0 -> RD_A with i=0; start=1 with len=0 -> DONE with no BRAM access.
REQ-017 RD_A: bram_en_b=1, bram_we_b=0, bram_addr_b=addr_a+i for one cycle -> WAIT_A.
REQ-018 WAIT_A: remain for RD_LATENCY cycles, then capture bram_dout_b into data_a -> RD_B.
REQ-019 RD_B/WAIT_B: same as RD_A/WAIT_A using addr_b+i, capturing into data_b -> WR.
REQ-020 WR: bram_en_b=1, bram_we_b=1, bram_addr_b=addr_out+i, bram_din_b=result(op,data_a,data_b) for one cycle; if i==len-1 -> DONE, else i<=i+1 -> RD_A.
REQ-021 DONE: done=1 for exactly one cycle -> IDLE.
REQ-022 Each element SHALL take exactly 3+2*RD_LATENCY cycles; total latency from start to done pulse SHALL be len*(3+2*RD_LATENCY)+1 cycles.
REQ-023 add/sub/mul SHALL wrap modulo 2^DATA_WIDTH; max SHALL compare as two's-complement signed.
REQ-024 Address sums SHALL wrap modulo 2^ADDR_WIDTH.
REQ-025 bram_en_b and bram_we_b SHALL be 0 in IDLE, WAIT_A, WAIT_B and DONE; bram_we_b SHALL be 1 only in WR.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next edge; no write SHALL be issued in that cycle (abort has priority over WR) and done SHALL NOT pulse.
REQ-028 abort and start together in IDLE: abort wins; the block SHALL stay in IDLE.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, i=0, done=0, busy=0, bram_en_b=0, bram_we_b=0, bram_addr_b=0, bram_din_b=0, data_a=0, data_b=0, from any state including mid-write.
REQ-030 After rst_n returns high, the block SHALL accept start on the first cycle.

Verification
REQ-031 op=0, len=4, A={1,2,3,4}, B={10,20,30,40}, RD_LATENCY=1 -> C={11,22,33,44}, done 21 cycles after start, exactly 4 writes.
REQ-032 op=1 with A=0, B=1 -> C=0xFFFFFFFF; op=2 with A=0x10000, B=0x10000 -> C=0; op=3 with A=0xFFFFFFFF, B=1 -> C=1.
REQ-033 len=0 -> done 1 cycle after start, bram_en_b never asserted.
REQ-034 addr_out=0x1FFE, len=4 -> writes at 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-035 abort asserted in WR of element 2 (len=5) -> element 2 not written, busy low next cycle, no done; new start then completes normally.
REQ-036 RD_LATENCY=3, len=2, start pulsed again mid-run -> 9 cycles per element, second start ignored, rst_n=0 mid-run clears all outputs next edge.

Source files
------------

// File: rtl/vec_alu_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// vec_alu_engine : element-wise C[i] = op(A[i], B[i]) over one BRAM port
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module vec_alu_engine #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [31:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr_b,
  output logic [DATA_WIDTH-1:0] bram_din_b,
  input  logic [DATA_WIDTH-1:0] bram_dout_b,
  output logic                  bram_en_b,
  output logic                  bram_we_b
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_WAIT_A, S_RD_B, S_WAIT_B, S_WR, S_DONE
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_out_q, addr_out_d;
  logic [31:0]           len_q, len_d, i_q, i_d;
  logic [1:0]            wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic                  busy_q, busy_d, done_q, done_d, en_q, en_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] result;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    addr_out_d = addr_out_q;
    len_d      = len_q;
    i_d        = i_q;
    wcnt_d     = wcnt_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          op_d       = op;
          addr_a_d   = addr_a;
          addr_b_d   = addr_b;
          addr_out_d = addr_out;
          len_d      = len;
          i_d        = 32'd0;
          wcnt_d     = 2'd0;
          state_d    = (len == 32'd0) ? S_DONE : S_RD_A;
        end
      end
      S_RD_A: begin
        wcnt_d  = 2'd0;
        state_d = S_WAIT_A;
      end
      S_WAIT_A: begin
        if (wcnt_q == WAIT_LAST) begin
          data_a_d = bram_dout_b;
          wcnt_d   = 2'd0;
          state_d  = S_RD_B;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_RD_B: begin
        wcnt_d  = 2'd0;
        state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (wcnt_q == WAIT_LAST) begin
          data_b_d = bram_dout_b;
          wcnt_d   = 2'd0;
          state_d  = S_WR;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_WR: begin
        if (i_q == len_q - 32'd1) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 32'd1;
          state_d = S_RD_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    case (op_d)
      2'd0:    result = data_a_d + data_b_d;
      2'd1:    result = data_a_d - data_b_d;
      2'd2:    result = data_a_d * data_b_d;
      default: result = ($signed(data_a_d) > $signed(data_b_d)) ? data_a_d : data_b_d;
    endcase
  end

  // Port outputs are registered from the next state so they line up with it.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    en_d   = (state_d == S_RD_A) || (state_d == S_RD_B) || (state_d == S_WR);
    we_d   = (state_d == S_WR);
    addr_d = '0;
    din_d  = '0;
    case (state_d)
      S_RD_A: addr_d = addr_a_d + i_d[ADDR_WIDTH-1:0];
      S_RD_B: addr_d = addr_b_d + i_d[ADDR_WIDTH-1:0];
      S_WR: begin
        addr_d = addr_out_d + i_d[ADDR_WIDTH-1:0];
        din_d  = result;
      end
      default: addr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_out_q <= '0;
      len_q      <= '0;
      i_q        <= '0;
      wcnt_q     <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      addr_out_q <= addr_out_d;
      len_q      <= len_d;
      i_q        <= i_d;
      wcnt_q     <= wcnt_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  // Abort must suppress the access already presented in the current cycle.
  assign bram_en_b   = en_q & ~abort;
  assign bram_we_b   = we_q & ~abort;
  assign bram_addr_b = addr_q;
  assign bram_din_b  = din_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_alu_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vec_alu_engine : scoreboard bench, RD_LATENCY=1 and RD_LATENCY=3 instances
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_vec_alu_engine;
  localparam int AW = 13;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n1, start1, abort1, busy1, done1, en1, we1;
  logic [1:0]    op1;
  logic [AW-1:0] aa1, ab1, ao1, baddr1;
  logic [31:0]   len1;
  logic [DW-1:0] din1, dout1;

  logic          rst_n3, start3, abort3, busy3, done3, en3, we3;
  logic [1:0]    op3;
  logic [AW-1:0] aa3, ab3, ao3, baddr3;
  logic [31:0]   len3;
  logic [DW-1:0] din3, dout3;

  vec_alu_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .start(start1), .abort(abort1), .op(op1),
    .addr_a(aa1), .addr_b(ab1), .addr_out(ao1), .len(len1),
    .busy(busy1), .done(done1), .bram_addr_b(baddr1), .bram_din_b(din1),
    .bram_dout_b(dout1), .bram_en_b(en1), .bram_we_b(we1));

  vec_alu_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n3), .start(start3), .abort(abort3), .op(op3),
    .addr_a(aa3), .addr_b(ab3), .addr_out(ao3), .len(len3),
    .busy(busy3), .done(done3), .bram_addr_b(baddr3), .bram_din_b(din3),
    .bram_dout_b(dout3), .bram_en_b(en3), .bram_we_b(we3));

  // Read-only memory image; writes are checked by the scoreboard only.
  logic [31:0] rd_tab [0:8191];
  logic [31:0] p3a, p3b;
  always @(posedge clk) dout1 <= rd_tab[baddr1];
  always @(posedge clk) begin
    p3a   <= rd_tab[baddr3];
    p3b   <= p3a;
    dout3 <= p3b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { logic [AW-1:0] a; logic [31:0] d; int c; } wr_t;
  wr_t wq1[$], wq3[$];
  int  dq1[$], dq3[$];
  int  en_cnt1 = 0, wr_cnt1 = 0, wr_cnt3 = 0;
  logic [31:0] exp_c [0:7];

  always @(negedge clk) begin : mon1
    wr_t e;
    int  dc;
    if (en1) en_cnt1++;
    if (en1 && we1) begin
      wr_cnt1++;
      if (wq1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected write: addr %0h data %0h, none expected", baddr1, din1);
      end else begin
        e = wq1.pop_front();
        chk("dut1 write addr", baddr1, e.a);
        chk("dut1 write data", din1, e.d);
        chk("dut1 write cycle", cyc, e.c);
      end
    end
    if (done1) begin
      if (dq1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected done at cycle %0d, none expected", cyc);
      end else begin
        dc = dq1.pop_front();
        chk("dut1 done cycle", cyc, dc);
      end
    end
  end

  always @(negedge clk) begin : mon3
    wr_t e;
    int  dc;
    if (en3 && we3) begin
      wr_cnt3++;
      if (wq3.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut3 unexpected write: addr %0h data %0h, none expected", baddr3, din3);
      end else begin
        e = wq3.pop_front();
        chk("dut3 write addr", baddr3, e.a);
        chk("dut3 write data", din3, e.d);
        chk("dut3 write cycle", cyc, e.c);
      end
    end
    if (done3) begin
      if (dq3.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut3 unexpected done at cycle %0d, none expected", cyc);
      end else begin
        dc = dq3.pop_front();
        chk("dut3 done cycle", cyc, dc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a start and queues nwr expected writes (data from exp_c) plus an optional done.
  task automatic issue(input int d, input logic [1:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] out, input logic [31:0] n, input int nwr, input bit ed,
                       output int t0);
    int  per;
    wr_t e;
    t0  = cyc;
    per = (d == 1) ? 5 : 9;
    for (int i = 0; i < nwr; i++) begin
      e.a = out + AW'(i);
      e.d = exp_c[i];
      e.c = t0 + (i + 1) * per;
      if (d == 1) wq1.push_back(e); else wq3.push_back(e);
    end
    if (ed) begin
      if (d == 1) dq1.push_back(t0 + int'(n) * per + 1); else dq3.push_back(t0 + int'(n) * per + 1);
    end
    if (d == 1) begin
      op1 = o; aa1 = a; ab1 = b; ao1 = out; len1 = n; start1 = 1'b1;
    end else begin
      op3 = o; aa3 = a; ab3 = b; ao3 = out; len3 = n; start3 = 1'b1;
    end
    tick();
    if (d == 1) begin
      start1 = 1'b0; op1 = ~o; aa1 = AW'($urandom); ab1 = AW'($urandom); ao1 = AW'($urandom); len1 = 32'd7;
    end else begin
      start3 = 1'b0; op3 = ~o; aa3 = AW'($urandom); ab3 = AW'($urandom); ao3 = AW'($urandom); len3 = 32'd7;
    end
  endtask

  task automatic wait_idle(input int d);
    int k;
    for (k = 0; k < 300; k++) begin
      tick();
      if (!((d == 1) ? busy1 : busy3)) break;
    end
    chk("busy drop within budget", (k < 300), 1);
  endtask

  int t0, base_en, base_wr;

  initial begin
    for (int i = 0; i < 8192; i++) rd_tab[i] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      rd_tab[13'h100 + i] = 32'(i + 1);
      rd_tab[13'h200 + i] = 32'((i + 1) * 10);
      rd_tab[13'h400 + i] = 32'(100 + i);
      rd_tab[13'h500 + i] = 32'(i);
    end
    for (int i = 0; i < 5; i++) begin
      rd_tab[13'h600 + i] = 32'(i + 1);
      rd_tab[13'h700 + i] = 32'd2;
    end
    rd_tab[13'h010] = 32'd0;        rd_tab[13'h020] = 32'd1;
    rd_tab[13'h011] = 32'h0001_0000; rd_tab[13'h021] = 32'h0001_0000;
    rd_tab[13'h012] = 32'hFFFF_FFFF; rd_tab[13'h022] = 32'd1;
    rd_tab[13'h013] = 32'd5;        rd_tab[13'h023] = 32'd3;
    rd_tab[13'h014] = 32'h8000_0000; rd_tab[13'h024] = 32'h7FFF_FFFF;

    rst_n1 = 0; start1 = 0; abort1 = 0; op1 = 0; aa1 = 0; ab1 = 0; ao1 = 0; len1 = 0;
    rst_n3 = 0; start3 = 0; abort3 = 0; op3 = 0; aa3 = 0; ab3 = 0; ao3 = 0; len3 = 0;
    repeat (3) tick();
    chk("reset busy", busy1, 0);
    chk("reset done", done1, 0);
    chk("reset en/we", {en1, we1, en3, we3}, 0);
    chk("reset addr/din", {baddr1, din1}, 0);
    rst_n1 = 1; rst_n3 = 1;
    tick();

    // add, len 4, second start while busy must be ignored
    exp_c[0] = 11; exp_c[1] = 22; exp_c[2] = 33; exp_c[3] = 44;
    base_wr = wr_cnt1;
    issue(1, 2'd0, 13'h100, 13'h200, 13'h300, 32'd4, 4, 1, t0);
    chk("busy after start", busy1, 1);
    repeat (3) tick();
    op1 = 2'd1; ao1 = 13'h1000; len1 = 32'd1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_idle(1);
    chk("add run write count", wr_cnt1 - base_wr, 4);

    // single-element op cases
    exp_c[0] = 32'hFFFF_FFFF; issue(1, 2'd1, 13'h010, 13'h020, 13'h030, 32'd1, 1, 1, t0); wait_idle(1);
    exp_c[0] = 32'h0;         issue(1, 2'd2, 13'h011, 13'h021, 13'h031, 32'd1, 1, 1, t0); wait_idle(1);
    exp_c[0] = 32'h1;         issue(1, 2'd3, 13'h012, 13'h022, 13'h032, 32'd1, 1, 1, t0); wait_idle(1);
    exp_c[0] = 32'h5;         issue(1, 2'd3, 13'h013, 13'h023, 13'h033, 32'd1, 1, 1, t0); wait_idle(1);
    exp_c[0] = 32'h7FFF_FFFF; issue(1, 2'd3, 13'h014, 13'h024, 13'h034, 32'd1, 1, 1, t0); wait_idle(1);
    exp_c[0] = 32'h0000_0001; issue(1, 2'd1, 13'h014, 13'h024, 13'h035, 32'd1, 1, 1, t0); wait_idle(1);

    // len 0: done next cycle, no BRAM access
    base_en = en_cnt1;
    issue(1, 2'd0, 13'h100, 13'h200, 13'h300, 32'd0, 0, 1, t0);
    wait_idle(1);
    chk("len0 no bram enable", en_cnt1 - base_en, 0);

    // output address wrap
    exp_c[0] = 100; exp_c[1] = 102; exp_c[2] = 104; exp_c[3] = 106;
    issue(1, 2'd0, 13'h400, 13'h500, 13'h1FFE, 32'd4, 4, 1, t0);
    wait_idle(1);

    // abort in WR of element 2 (cycle t0+15), then a clean run
    exp_c[0] = 2; exp_c[1] = 4;
    issue(1, 2'd2, 13'h600, 13'h700, 13'h800, 32'd5, 2, 0, t0);
    while (cyc < t0 + 15) tick();
    chk("in WR before abort", we1, 1);
    abort1 = 1'b1;
    #1 chk("abort gates write", we1, 0);
    tick();
    abort1 = 1'b0;
    chk("busy after abort", busy1, 0);
    repeat (3) tick();
    // abort together with start in IDLE: stays idle
    abort1 = 1'b1; start1 = 1'b1; op1 = 2'd0; len1 = 32'd1;
    tick();
    abort1 = 1'b0; start1 = 1'b0;
    chk("abort beats start", busy1, 0);
    exp_c[0] = 2; exp_c[1] = 4;
    issue(1, 2'd2, 13'h600, 13'h700, 13'h810, 32'd2, 2, 1, t0);
    wait_idle(1);

    // RD_LATENCY=3: 9 cycles per element, second start ignored
    exp_c[0] = 11; exp_c[1] = 22;
    base_wr = wr_cnt3;
    issue(3, 2'd0, 13'h100, 13'h200, 13'h300, 32'd2, 2, 1, t0);
    repeat (4) tick();
    op3 = 2'd1; ao3 = 13'h0900; len3 = 32'd3; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    wait_idle(3);
    chk("lat3 write count", wr_cnt3 - base_wr, 2);

    // reset during the write of element 1
    exp_c[0] = 11; exp_c[1] = 22;
    issue(3, 2'd0, 13'h100, 13'h200, 13'h380, 32'd2, 2, 0, t0);
    while (cyc < t0 + 18) tick();
    chk("lat3 in WR before reset", we3, 1);
    rst_n3 = 1'b0;
    tick();
    chk("mid reset busy/done", {busy3, done3}, 0);
    chk("mid reset en/we", {en3, we3}, 0);
    chk("mid reset addr", baddr3, 0);
    chk("mid reset din", din3, 0);
    rst_n3 = 1'b1;
    exp_c[0] = 33;
    issue(3, 2'd0, 13'h102, 13'h202, 13'h390, 32'd1, 1, 1, t0);
    chk("start right after reset", busy3, 1);
    wait_idle(3);

    repeat (3) tick();
    chk("dut1 writes drained", wq1.size(), 0);
    chk("dut1 dones drained", dq1.size(), 0);
    chk("dut3 writes drained", wq3.size(), 0);
    chk("dut3 dones drained", dq3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
